// File: rtl/i2s_playback_serializer.sv
// I2S playback serializer: frame FIFO plus MSB-first shifter timed by the CODEC bclk/lrclk.
// Define I2S_UNDERRUN_REPEAT_EN to replay the last popped frame on underrun instead of zeros.
module i2s_playback_serializer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SAMPLE_BITS = 24,
    parameter int UNDERRUN_W  = 16
) (
    input  logic                          board_clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          underrun_clr,
    input  logic [63:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          ac_bclk,
    input  logic                          ac_pblrc,
    output logic                          ac_pbdat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [UNDERRUN_W-1:0]         underrun_count,
    output logic                          frame_pulse
);
    // state | meaning
    // IDLE  | output held low, waiting for a left_start with enable
    // LEFT  | serializing the left word
    // RIGHT | serializing the right word
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int SB = SAMPLE_BITS;

    logic bclk_m, bclk_s, bclk_d, lrc_m, lrc_s, lrc_q;
    logic bclk_fall, left_start, right_start;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            bclk_m <= 1'b0;
            bclk_s <= 1'b0;
            bclk_d <= 1'b0;
            lrc_m  <= 1'b0;
            lrc_s  <= 1'b0;
            lrc_q  <= 1'b0;
        end else begin
            bclk_m <= ac_bclk;
            bclk_s <= bclk_m;
            bclk_d <= bclk_s;
            lrc_m  <= ac_pblrc;
            lrc_s  <= lrc_m;
            if (bclk_fall) lrc_q <= lrc_s;
        end
    end

    assign bclk_fall   = bclk_d & ~bclk_s;
    assign left_start  = bclk_fall & lrc_q & ~lrc_s;
    assign right_start = bclk_fall & ~lrc_q & lrc_s;

    // Only the sampled top bits of each half are stored.
    logic [2*SB-1:0] mem [FIFO_DEPTH];
    logic [2*SB-1:0] head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   count;
    logic            ready_en, full, empty, push, pop, load_left, underrun;

    generate
        if (SB < 32) begin : g_trim
            logic unused_tdata;
            assign unused_tdata = ^{s_axis_tdata[63-SB:32], s_axis_tdata[31-SB:0]};
        end
    endgenerate

    assign full          = (count == LW'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign s_axis_tready = ready_en & ~full;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign load_left     = left_start & enable;
    assign pop           = load_left & ~empty;
    assign underrun      = load_left & empty;
    assign head          = mem[rd_ptr];
    assign fifo_level    = count;

    always_ff @(posedge board_clk) begin
        if (push) mem[wr_ptr] <= {s_axis_tdata[63 -: SB], s_axis_tdata[31 -: SB]};
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    state_t state, state_next;
    logic   active, load_right;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (left_start)  state_next = LEFT;
                LEFT:    if (right_start) state_next = RIGHT;
                RIGHT:   if (left_start)  state_next = LEFT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        active     = (state != IDLE);
        load_right = right_start & (state == LEFT);
    end

    logic [SB-1:0] shifter, hold_right, fill_left, fill_right;

`ifdef I2S_UNDERRUN_REPEAT_EN
    logic [SB-1:0] last_left, last_right;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            last_left  <= '0;
            last_right <= '0;
        end else if (pop) begin
            last_left  <= head[2*SB-1 -: SB];
            last_right <= head[SB-1:0];
        end
    end

    assign fill_left  = last_left;
    assign fill_right = last_right;
`else
    assign fill_left  = '0;
    assign fill_right = '0;
`endif

    // The load bclk only reloads; ac_pbdat keeps the previous bit (I2S one-bit delay).
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            shifter    <= '0;
            hold_right <= '0;
            ac_pbdat   <= 1'b0;
        end else if (!enable) begin
            shifter    <= '0;
            ac_pbdat   <= 1'b0;
        end else if (load_left) begin
            shifter    <= empty ? fill_left  : head[2*SB-1 -: SB];
            hold_right <= empty ? fill_right : head[SB-1:0];
        end else if (load_right) begin
            shifter    <= hold_right;
        end else if (bclk_fall && active) begin
            ac_pbdat   <= shifter[SB-1];
            shifter    <= {shifter[SB-2:0], 1'b0};
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            frame_pulse    <= 1'b0;
            underrun_count <= '0;
        end else begin
            frame_pulse <= load_left;
            if (underrun_clr)
                underrun_count <= '0;
            else if (underrun && !(&underrun_count))
                underrun_count <= underrun_count + UNDERRUN_W'(1);
        end
    end

endmodule

// File: tb/tb_i2s_playback_serializer.sv
// Scoreboard bench: expected serial bits come from a frame-level I2S model and are
// checked by a monitor on each rising ac_bclk.
module tb_i2s_playback_serializer;
    localparam int DEPTH = 8;
    localparam int SB    = 24;
    localparam int UW    = 4;

    logic          board_clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          underrun_clr = 1'b0;
    logic [63:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          ac_bclk = 1'b1;
    logic          ac_pblrc = 1'b1;
    logic          ac_pbdat;
    logic [3:0]    fifo_level;
    logic [UW-1:0] underrun_count;
    logic          frame_pulse;

    i2s_playback_serializer #(.FIFO_DEPTH(DEPTH), .SAMPLE_BITS(SB), .UNDERRUN_W(UW)) dut (
        .board_clk(board_clk), .reset(reset), .enable(enable), .underrun_clr(underrun_clr),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .ac_bclk(ac_bclk), .ac_pblrc(ac_pblrc), .ac_pbdat(ac_pbdat), .fifo_level(fifo_level),
        .underrun_count(underrun_count), .frame_pulse(frame_pulse)
    );

    always #5 board_clk = ~board_clk;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          exp_q[$];
    logic [63:0] m_q[$];
    logic [63:0] m_last = '0;
    int          m_ucount = 0;
    bit          m_active = 1'b0;
    bit          m_prev = 1'b0;
    int          exp_fp = 0;
    int          seen_fp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            bit e;
            @(posedge ac_bclk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pbdat_sb: no expected bit queued at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pbdat", ac_pbdat, e);
                end
            end
        end
    end

    always @(negedge board_clk) if (frame_pulse === 1'b1) seen_fp++;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_tready"}, s_axis_tready, 0);
        check({tag, "_pbdat"}, ac_pbdat, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_ucount"}, underrun_count, 0);
        check({tag, "_fpulse"}, frame_pulse, 0);
    endtask

    task automatic release_reset();
        @(negedge board_clk);
        reset = 1'b0;
        @(negedge board_clk);
        check("tready_after_reset", s_axis_tready, 1);
    endtask

    task automatic set_enable(input bit v);
        @(negedge board_clk);
        enable = v;
        if (!v) begin
            m_active = 1'b0;
            m_prev   = 1'b0;
        end
    endtask

    task automatic push_one(input logic [63:0] f, output bit acc);
        @(negedge board_clk);
        s_axis_tdata  = f;
        s_axis_tvalid = 1'b1;
        acc = (m_q.size() < DEPTH);
        check("tready", s_axis_tready, acc);
        if (acc) m_q.push_back(f);
        @(posedge board_clk);
    endtask

    task automatic bus_idle();
        @(negedge board_clk);
        s_axis_tvalid = 1'b0;
        check("fifo_level", fifo_level, m_q.size());
    endtask

    // Model of one LR half: first bclk repeats the previous bit, then SB bits MSB-first, then zeros.
    task automatic drive_half(input bit lrc_v, input int n, input logic [31:0] word,
                              input int dis_k, input int en_k, input int rst_k);
        for (int k = 0; k < n; k++) begin
            bit e;
            @(negedge board_clk);
            ac_bclk  = 1'b0;
            ac_pblrc = lrc_v;
            if (k == 0)                    e = m_prev;
            else if (m_active && k <= SB)  e = word[SB-k];
            else                           e = 1'b0;
            exp_q.push_back(e);
            m_prev = e;
            repeat (8) @(negedge board_clk);
            ac_bclk = 1'b1;
            if (k == rst_k) begin
                #2 reset = 1'b1;
                #1 check_reset_vals("mid_reset");
                exp_q.delete();
                m_q.delete();
                m_last   = '0;
                m_ucount = 0;
                m_active = 1'b0;
                m_prev   = 1'b0;
                return;
            end
            if (k == dis_k) begin
                enable   = 1'b0;
                m_active = 1'b0;
                m_prev   = 1'b0;
                @(negedge board_clk);
                check("pbdat_after_disable", ac_pbdat, 0);
                repeat (6) @(negedge board_clk);
            end else begin
                if (k == en_k) enable = 1'b1;
                repeat (7) @(negedge board_clk);
            end
        end
    endtask

    task automatic begin_frame(output logic [31:0] lw, output logic [31:0] rw);
        logic [63:0] f;
        lw = '0;
        rw = '0;
        if (enable) begin
            m_active = 1'b1;
            exp_fp++;
            if (m_q.size() > 0) begin
                f = m_q.pop_front();
                m_last = f;
            end else begin
                if (m_ucount < (1 << UW) - 1) m_ucount++;
`ifdef I2S_UNDERRUN_REPEAT_EN
                f = m_last;
`else
                f = '0;
`endif
            end
            lw[SB-1:0] = f[63 -: SB];
            rw[SB-1:0] = f[31 -: SB];
        end
    endtask

    task automatic run_frame(input int nl, input int nr, input int dis_k, input int en_k);
        logic [31:0] lw, rw;
        begin_frame(lw, rw);
        drive_half(1'b0, nl, lw, dis_k, -1, -1);
        drive_half(1'b1, nr, rw, -1, en_k, -1);
    endtask

    initial begin
        bit          acc;
        logic [63:0] f9;
        logic [31:0] lw, rw;

        repeat (3) @(negedge board_clk);
        check_reset_vals("reset");
        release_reset();
        mon_en = 1'b1;
        drive_half(1'b1, 2, '0, -1, -1, -1);

        // Basic frame
        push_one(64'hCAFECAFE_DEADBEEF, acc);
        bus_idle();
        set_enable(1'b1);
        run_frame(32, 32, -1, -1);
        check("level_after_frame", fifo_level, m_q.size());
        check("fp_basic", seen_fp, exp_fp);

        // Backpressure: 9th frame stays on the bus until the first pop
        set_enable(1'b0);
        for (int i = 0; i < 9; i++) begin
            f9 = {$urandom, $urandom};
            push_one(f9, acc);
        end
        @(negedge board_clk);
        check("level_full", fifo_level, m_q.size());
        check("tready_full", s_axis_tready, m_q.size() < DEPTH);
        set_enable(1'b1);
        fork
            run_frame(32, 32, -1, -1);
            begin
                bit found = 1'b0;
                for (int i = 0; i < 100 && !found; i++) begin
                    @(negedge board_clk);
                    if (fifo_level == 4'd7) found = 1'b1;
                end
                if (!found) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_timeout: fifo_level never dropped, still %0d", fifo_level);
                end else begin
                    check("tready_after_pop", s_axis_tready, m_q.size() < DEPTH);
                    @(posedge board_clk);
                    @(negedge board_clk);
                    m_q.push_back(f9);
                    check("level_refill", fifo_level, m_q.size());
                    check("tready_refull", s_axis_tready, m_q.size() < DEPTH);
                end
                s_axis_tvalid = 1'b0;
            end
        join
        for (int i = 0; i < 8; i++) run_frame(26, 26, -1, -1);
        check("level_drained", fifo_level, m_q.size());
        check("ucount_none", underrun_count, m_ucount);

        // Underrun with empty FIFO, then clear
        for (int i = 0; i < 3; i++) run_frame(32, 32, -1, -1);
        check("ucount_3", underrun_count, m_ucount);
        @(negedge board_clk) underrun_clr = 1'b1;
        @(negedge board_clk) underrun_clr = 1'b0;
        m_ucount = 0;
        check("ucount_clr", underrun_count, m_ucount);

        // Clear held across the underrun increment wins
        fork
            run_frame(32, 32, -1, -1);
            begin
                @(negedge board_clk) underrun_clr = 1'b1;
                repeat (3) @(negedge board_clk);
                underrun_clr = 1'b0;
            end
        join
        m_ucount = 0;
        check("ucount_clr_prio", underrun_count, m_ucount);

        // Saturation
        for (int i = 0; i < 20; i++) run_frame(6, 6, -1, -1);
        check("ucount_sat", underrun_count, m_ucount);
        @(negedge board_clk) underrun_clr = 1'b1;
        @(negedge board_clk) underrun_clr = 1'b0;
        m_ucount = 0;

        // Enable dropped mid-left, restored mid-right
        push_one({$urandom, $urandom}, acc);
        push_one({$urandom, $urandom}, acc);
        bus_idle();
        run_frame(32, 32, 10, 5);
        run_frame(32, 32, -1, -1);
        check("level_mid_en", fifo_level, m_q.size());
        check("fp_mid_en", seen_fp, exp_fp);

        // Reset during the right half with three frames stored
        for (int i = 0; i < 4; i++) push_one({$urandom, $urandom}, acc);
        bus_idle();
        begin_frame(lw, rw);
        drive_half(1'b0, 32, lw, -1, -1, -1);
        check("level_before_reset", fifo_level, m_q.size());
        drive_half(1'b1, 32, rw, -1, -1, 5);
        enable        = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (2) @(negedge board_clk);
        check_reset_vals("held_reset");
        release_reset();
        drive_half(1'b1, 3, '0, -1, -1, -1);

        // Random traffic with short and long LR halves
        for (int fr = 0; fr < 12; fr++) begin
            int np;
            np = $urandom_range(0, 2);
            for (int i = 0; i < np; i++)
                if (m_q.size() < DEPTH) push_one({$urandom, $urandom}, acc);
            if (np > 0) bus_idle();
            set_enable($urandom_range(0, 5) != 0);
            run_frame($urandom_range(18, 40), $urandom_range(18, 40), -1, -1);
        end

        @(negedge board_clk);
        check("level_final", fifo_level, m_q.size());
        check("ucount_final", underrun_count, m_ucount);
        check("fp_final", seen_fp, exp_fp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
